// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS generator/checker pair.
// Tap masks use bit i = state bit i feeding the XOR; stored 32 bits wide, slice to WIDTH.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [31:0] TAPS_PRBS7  = 32'h0000_0060; // x^7+x^6+1
  localparam logic [31:0] TAPS_PRBS8  = 32'h0000_00B8; // x^8+x^6+x^5+x^4+1
  localparam logic [31:0] TAPS_PRBS15 = 32'h0000_6000; // x^15+x^14+1
  localparam logic [31:0] TAPS_PRBS23 = 32'h0042_0000; // x^23+x^18+1
  localparam logic [31:0] TAPS_PRBS31 = 32'h4800_0000; // x^31+x^28+1

  localparam int unsigned SEED_CNT_W  = 6;
  localparam int unsigned MATCH_CNT_W = 8;
  localparam int unsigned ERR_CNT_W   = 16;
  localparam int unsigned BIT_CNT_W   = 32;

endpackage

// File: rtl/prbs_lfsr_reg.sv
// Fibonacci LFSR register: shifts x in at bit 0 on request, exposes the tap-XOR prediction.
module prbs_lfsr_reg #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic             x,
  output logic [WIDTH-1:0] state,
  output logic             pred
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (shift) begin
      state <= {state[WIDTH-2:0], x};
    end
  end

  assign pred = ^(state & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: seeds its LFSR from the stream, verifies, locks,
// then counts bit errors against the free-running prediction and unlocks on an error burst.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] TAPS        = TAPS_PRBS8,
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned UNLOCK_ERRS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [BIT_CNT_W-1:0] bit_count
);

  localparam int unsigned WB_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned WE_W = $clog2(UNLOCK_ERRS + 1);

  state_t                 fsm_q, fsm_d;
  logic [SEED_CNT_W-1:0]  seed_cnt_q, seed_cnt_d;
  logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [WB_W-1:0]        win_bits_q, win_bits_d;
  logic [WE_W-1:0]        win_errs_q, win_errs_d, win_errs_nxt;

  logic [WIDTH-1:0] lfsr_state;
  logic [WIDTH-1:0] shifted;
  logic             pred;
  logic             lfsr_x;
  logic             mismatch;
  logic             locked_err;
  logic             count_bit;

  prbs_lfsr_reg #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS[WIDTH-1:0])
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (in_valid),
    .x     (lfsr_x),
    .state (lfsr_state),
    .pred  (pred)
  );

  always_comb begin
    fsm_d        = fsm_q;
    seed_cnt_d   = seed_cnt_q;
    match_cnt_d  = match_cnt_q;
    win_bits_d   = win_bits_q;
    win_errs_d   = win_errs_q;
    win_errs_nxt = win_errs_q;
    lfsr_x       = in_bit;
    locked_err   = 1'b0;
    count_bit    = 1'b0;
    mismatch     = (pred != in_bit);
    // LFSR contents after this bit is shifted in; the all-zero guard looks at this value
    shifted      = (lfsr_state << 1) | WIDTH'(in_bit);

    if (in_valid) begin
      unique case (fsm_q)
        SEED: begin
          if (seed_cnt_q == SEED_CNT_W'(WIDTH - 1)) begin
            seed_cnt_d = '0;
            if (shifted != '0) fsm_d = VERIFY;
          end else begin
            seed_cnt_d = seed_cnt_q + 1'b1;
          end
        end

        VERIFY: begin
          if (mismatch) begin
            fsm_d       = SEED;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else if (match_cnt_q == MATCH_CNT_W'(LOCK_CNT - 1)) begin
            fsm_d       = LOCKED;
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end

        LOCKED: begin
          lfsr_x       = pred;
          count_bit    = 1'b1;
          locked_err   = mismatch;
          win_errs_nxt = win_errs_q + WE_W'(mismatch);
          win_bits_d   = (win_bits_q == WB_W'(WINDOW - 1)) ? '0 : win_bits_q + 1'b1;
          // Hitting the error limit takes priority over a window wrap on the same bit
          if (win_errs_nxt == WE_W'(UNLOCK_ERRS)) begin
            fsm_d      = SEED;
            seed_cnt_d = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else if (win_bits_q == WB_W'(WINDOW - 1)) begin
            win_errs_d = '0;
          end else begin
            win_errs_d = win_errs_nxt;
          end
        end

        default: fsm_d = SEED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= SEED;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      bit_count   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      locked      <= (fsm_d == LOCKED);
      err_pulse   <= locked_err;
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
      end else begin
        if (locked_err && (err_count != '1)) err_count <= err_count + 1'b1;
        if (count_bit && (bit_count != '1)) bit_count <= bit_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Scenario bench for prbs_checker (PRBS8 defaults): reference generator drives the stream,
// per-bit expectations are queued at drive time and popped after the clock edge.
module tb_prbs_checker;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit   = 1'b0;
  logic        clear    = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  always #5 clk = ~clk;

  prbs_checker #(
    .WIDTH       (8),
    .TAPS        (32'h0000_00B8),
    .LOCK_CNT    (16),
    .WINDOW      (64),
    .UNLOCK_ERRS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  typedef struct packed {
    logic lk;
    logic ep;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [7:0]  gen    = 8'hA5;

  task automatic next_bit(output logic b);
    b   = ^(gen & 8'hB8);
    gen = {gen[6:0], b};
  endtask

  task automatic drive(input logic v, input logic b, input logic clr, input logic lk, input logic ep);
    in_valid = v;
    in_bit   = b;
    clear    = clr;
    sb.push_back(exp_t'{lk, ep});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passed++;
    checks++; if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse: got %b want 0", err_pulse); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL reset_err_count: got %0d want 0", err_count); else passed++;
    checks++; if (bit_count !== 32'd0) $display("FAIL reset_bit_count: got %0d want 0", bit_count); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    logic b;
    exp_t e;
    for (int k = 1; k <= 64; k++) begin
      next_bit(b);
      drive(1'b1, b, 1'b0, (k >= 24), 1'b0);
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || err_pulse !== e.ep)
        $display("FAIL clean_lock bit %0d: locked=%b err_pulse=%b want %b %b", k, locked, err_pulse, e.lk, e.ep);
      else passed++;
    end
    checks++; if (err_count !== 16'd0) $display("FAIL clean_err_count: got %0d want 0", err_count); else passed++;
    checks++; if (bit_count !== 32'd40) $display("FAIL clean_bit_count: got %0d want 40", bit_count); else passed++;
  endtask

  task automatic test_single_error();
    logic b, flip;
    exp_t e;
    for (int k = 1; k <= 21; k++) begin
      next_bit(b);
      flip = (k == 11);
      drive(1'b1, b ^ flip, 1'b0, 1'b1, flip);
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || err_pulse !== e.ep)
        $display("FAIL single_error bit %0d: locked=%b err_pulse=%b want %b %b", k, locked, err_pulse, e.lk, e.ep);
      else passed++;
    end
    checks++; if (err_count !== 16'd1) $display("FAIL single_err_count: got %0d want 1", err_count); else passed++;
    checks++; if (bit_count !== 32'd61) $display("FAIL single_bit_count: got %0d want 61", bit_count); else passed++;
  endtask

  task automatic test_unlock_relock();
    logic b, flip, lk;
    exp_t e;
    int   j;
    apply_reset();
    for (int k = 1; k <= 24 + 59; k++) begin
      j    = k - 24;
      next_bit(b);
      flip = (j == 5) || (j == 15) || (j == 25) || (j == 35);
      lk   = (k >= 24 && j < 35) || (j >= 59);
      drive(1'b1, b ^ flip, 1'b0, lk, flip);
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || err_pulse !== e.ep)
        $display("FAIL unlock_relock bit %0d: locked=%b err_pulse=%b want %b %b", k, locked, err_pulse, e.lk, e.ep);
      else passed++;
    end
    checks++; if (err_count !== 16'd4) $display("FAIL unlock_err_count: got %0d want 4", err_count); else passed++;
  endtask

  task automatic test_window_wrap();
    logic b, flip;
    exp_t e;
    int   j;
    apply_reset();
    for (int k = 1; k <= 24 + 80; k++) begin
      j    = k - 24;
      next_bit(b);
      flip = (j == 10) || (j == 20) || (j == 30) || (j == 70);
      drive(1'b1, b ^ flip, 1'b0, (k >= 24), flip);
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || err_pulse !== e.ep)
        $display("FAIL window_wrap bit %0d: locked=%b err_pulse=%b want %b %b", k, locked, err_pulse, e.lk, e.ep);
      else passed++;
    end
    checks++; if (err_count !== 16'd4) $display("FAIL wrap_err_count: got %0d want 4", err_count); else passed++;
    checks++; if (bit_count !== 32'd80) $display("FAIL wrap_bit_count: got %0d want 80", bit_count); else passed++;
  endtask

  task automatic test_all_zero();
    exp_t e;
    apply_reset();
    for (int k = 1; k <= 1000; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || err_pulse !== e.ep)
        $display("FAIL all_zero cycle %0d: locked=%b err_pulse=%b want %b %b", k, locked, err_pulse, e.lk, e.ep);
      else passed++;
    end
    checks++; if (err_count !== 16'd0) $display("FAIL zero_err_count: got %0d want 0", err_count); else passed++;
    checks++; if (bit_count !== 32'd0) $display("FAIL zero_bit_count: got %0d want 0", bit_count); else passed++;
  endtask

  task automatic test_gaps();
    logic        b, v;
    exp_t        e;
    int unsigned nv = 0;
    int unsigned cyc = 0;
    apply_reset();
    while (nv < 54 && cyc < 1000) begin
      cyc++;
      v = 1'($urandom_range(0, 1));
      if (v) begin
        next_bit(b);
        nv++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      drive(v, b, 1'b0, (nv >= 24), 1'b0);
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || err_pulse !== e.ep)
        $display("FAIL gaps cycle %0d (valid %0d): locked=%b err_pulse=%b want %b %b", cyc, nv, locked, err_pulse, e.lk, e.ep);
      else passed++;
    end
    checks++; if (nv != 54) $display("FAIL gaps_budget: sent %0d valid bits want 54", nv); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL gaps_err_count: got %0d want 0", err_count); else passed++;
    checks++; if (bit_count !== 32'd30) $display("FAIL gaps_bit_count: got %0d want 30", bit_count); else passed++;
  endtask

  task automatic test_clear_with_error();
    logic b, flip;
    exp_t e;
    for (int k = 1; k <= 7; k++) begin
      next_bit(b);
      flip = (k == 6);
      drive(1'b1, b ^ flip, (k == 6), 1'b1, flip);
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || err_pulse !== e.ep)
        $display("FAIL clear_error bit %0d: locked=%b err_pulse=%b want %b %b", k, locked, err_pulse, e.lk, e.ep);
      else passed++;
      if (k == 6) begin
        checks++; if (err_count !== 16'd0) $display("FAIL clear_err_count: got %0d want 0", err_count); else passed++;
        checks++; if (bit_count !== 32'd0) $display("FAIL clear_bit_count: got %0d want 0", bit_count); else passed++;
      end
    end
    checks++; if (bit_count !== 32'd1) $display("FAIL after_clear_bit_count: got %0d want 1", bit_count); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL after_clear_err_count: got %0d want 0", err_count); else passed++;
  endtask

  task automatic test_reset_mid_lock();
    logic b, flip;
    exp_t e;
    for (int k = 1; k <= 2; k++) begin
      next_bit(b);
      flip = (k == 1);
      drive(1'b1, b ^ flip, 1'b0, 1'b1, flip);
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || err_pulse !== e.ep)
        $display("FAIL pre_reset bit %0d: locked=%b err_pulse=%b want %b %b", k, locked, err_pulse, e.lk, e.ep);
      else passed++;
    end
    checks++; if (err_count !== 16'd1) $display("FAIL pre_reset_err_count: got %0d want 1", err_count); else passed++;
    checks++; if (bit_count !== 32'd3) $display("FAIL pre_reset_bit_count: got %0d want 3", bit_count); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) $display("FAIL async_reset_locked: got %b want 0", locked); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL async_reset_err_count: got %0d want 0", err_count); else passed++;
    checks++; if (bit_count !== 32'd0) $display("FAIL async_reset_bit_count: got %0d want 0", bit_count); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      next_bit(b);
      drive(1'b1, b, 1'b0, (k >= 24), 1'b0);
      e = sb.pop_front();
      checks++;
      if (locked !== e.lk || err_pulse !== e.ep)
        $display("FAIL relock_after_reset bit %0d: locked=%b err_pulse=%b want %b %b", k, locked, err_pulse, e.lk, e.ep);
      else passed++;
    end
    checks++; if (bit_count !== 32'd6) $display("FAIL relock_bit_count: got %0d want 6", bit_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_unlock_relock();
    test_window_wrap();
    test_all_zero();
    test_gaps();
    test_clear_with_error();
    test_reset_mid_lock();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
